// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared constants and state encoding for the Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    localparam int BOOTH_W    = 8;
    localparam int BOOTH_ITER = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_substep.sv
`default_nettype none
// ============================================================================
// Module      : booth_substep
// Description : One radix-2 Booth iteration: conditional add/subtract of M
//               followed by an arithmetic right shift of {acc, Q, q-1}.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_substep
    import booth_pkg::*;
(
    input  logic [BOOTH_W-1:0] i_acc,
    input  logic [BOOTH_W-1:0] i_q,
    input  logic               i_q0,
    input  logic [BOOTH_W-1:0] i_m,
    output logic [BOOTH_W-1:0] o_next_acc,
    output logic [BOOTH_W-1:0] o_next_q,
    output logic               o_next_q0
);

    logic [BOOTH_W-1:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_q0})
            2'b10:   w_sum = i_acc - i_m;
            2'b01:   w_sum = i_acc + i_m;
            default: w_sum = i_acc;
        endcase
    end

    assign o_next_acc = {w_sum[BOOTH_W-1], w_sum[BOOTH_W-1:1]};
    assign o_next_q   = {w_sum[0], i_q[BOOTH_W-1:1]};
    assign o_next_q0  = i_q[0];

endmodule
`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_multiplier
// Description : Sequential signed 8x8 radix-2 Booth multiplier with
//               valid/ready handshakes; fixed 8-iteration latency.
//               Optional macro BOOTH_RANGE_CHK_EN adds the range_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
`ifdef BOOTH_RANGE_CHK_EN
    ,
    output logic               range_err
`endif
);

    localparam int                 c_CNT_W    = $clog2(BOOTH_ITER);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BOOTH_ITER - 1);

    if (WIDTH != BOOTH_W) begin : g_width_check
        $error("booth_seq_multiplier: only WIDTH=8 is supported");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q0;
    logic [WIDTH-1:0]     r_m;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH-1:0]     w_next_acc;
    logic [WIDTH-1:0]     w_next_q;
    logic                 w_next_q0;
    logic                 w_accept;
    logic                 w_finish;
    logic                 w_release;

    booth_substep u_substep (
        .i_acc      (r_acc),
        .i_q        (r_q),
        .i_q0       (r_q0),
        .i_m        (r_m),
        .o_next_acc (w_next_acc),
        .o_next_q   (w_next_q),
        .o_next_q0  (w_next_q0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Product is captured from the final substep so it stays frozen outside DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_q       <= '0;
            r_q0      <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_q   <= multiplier;
            r_q0  <= 1'b0;
            r_m   <= multiplicand;
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc <= w_next_acc;
            r_q   <= w_next_q;
            r_q0  <= w_next_q0;
            r_cnt <= r_cnt + 1'b1;
            if (w_finish) begin
                r_product <= {w_next_acc, w_next_q};
            end
        end
    end

    assign product = r_product;

`ifdef BOOTH_RANGE_CHK_EN
    logic r_range_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_range_hit <= 1'b0;
        end else if (w_accept) begin
            r_range_hit <= (multiplicand == {1'b1, {(WIDTH-1){1'b0}}});
        end else if (w_release) begin
            r_range_hit <= 1'b0;
        end
    end

    assign range_err = r_range_hit && (r_state == ST_DONE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_multiplier
// Description : Self-checking bench for booth_seq_multiplier against a
//               behavioural multiply/handshake model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_multiplier;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        in_valid     = 1'b0;
    logic        out_ready    = 1'b0;
    logic [7:0]  multiplicand = 8'h00;
    logic [7:0]  multiplier   = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] product;
`ifdef BOOTH_RANGE_CHK_EN
    logic        range_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_seq_multiplier #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
`ifdef BOOTH_RANGE_CHK_EN
        ,
        .range_err    (range_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting for operands, 1 = computing, 2 = result offered
    int          m_phase   = 0;
    int          m_left    = 0;
    int          m_prod    = 0;
    logic [15:0] m_exp     = 16'h0;
    logic [15:0] m_last    = 16'h0;
    bit          m_rng     = 1'b0;
    bit          m_skip    = 1'b0;
    bit          m_unknown = 1'b0;
    bit          m_on      = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_last = 16'h0; m_rng = 1'b0;
            m_skip = 1'b0; m_unknown = 1'b0; m_on = 1'b1;
        end else if (m_on) begin
            case (m_phase)
                0: if (in_valid) begin
                    m_prod  = int'($signed(multiplicand)) * int'($signed(multiplier));
                    m_exp   = m_prod[15:0];
                    m_rng   = (multiplicand == 8'h80);
                    m_skip  = (multiplicand == 8'h80);
                    m_left  = 8;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase   = 2;
                        m_last    = m_exp;
                        m_unknown = m_skip;
                    end
                end
                default: if (out_ready) begin
                    m_phase = 0;
                    m_rng   = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_on && !rst) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            if (!m_unknown) chk("product", product, m_last);
`ifdef BOOTH_RANGE_CHK_EN
            chk("range_err", range_err, (m_phase == 2) && m_rng);
`endif
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int bp,
                         input bit poke, input bit use_lit, input logic [15:0] lit);
        int t;
        int n;
        t = 0;
        while (!in_ready && t < 40) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
        multiplicand = a; multiplier = b; in_valid = 1'b1;
        out_ready = (bp == 0);
        n = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        multiplicand = 8'($urandom); multiplier = 8'($urandom);
        if (poke) begin
            @(posedge clk); #1;
            in_valid = 1'b1; multiplicand = 8'h55; multiplier = 8'h66;
            repeat (2) begin @(posedge clk); #1; end
            in_valid = 1'b0;
        end
        t = 0;
        while (!out_valid && t < 40) begin @(posedge clk); #1; t++; end
        if (!out_valid) begin chk("out_valid_timeout", 0, 1); return; end
        chk("latency", cyc - n, 9);
        if (use_lit) chk("product_lit", product, lit);
`ifdef BOOTH_RANGE_CHK_EN
        chk("range_err_lit", range_err, a == 8'h80);
`endif
        repeat (bp) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_product_lit", product, 16'h0000);
        chk("reset_in_ready_lit", in_ready, 1);
        chk("reset_out_valid_lit", out_valid, 0);
        @(posedge clk); #1;

        do_op(8'd7, 8'd3, 0, 1'b0, 1'b1, 16'd21);
        do_op(8'hFB, 8'd6, 0, 1'b0, 1'b1, 16'hFFE2);
        do_op(8'h7F, 8'h80, 0, 1'b0, 1'b1, 16'hC080);
        do_op(8'd9, 8'd10, 5, 1'b0, 1'b1, 16'h005A);
        do_op(8'd20, 8'hFD, 1, 1'b1, 1'b1, 16'hFFC4);

        // Abort a multiply on its 4th RUN cycle
        multiplicand = 8'h33; multiplier = 8'h44; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready_lit", in_ready, 1);
        chk("abort_out_valid_lit", out_valid, 0);
        chk("abort_product_lit", product, 16'h0000);
        @(posedge clk); #1;
        do_op(8'd12, 8'hF4, 0, 1'b0, 1'b1, 16'hFF70);

`ifdef BOOTH_RANGE_CHK_EN
        do_op(8'h80, 8'd1, 0, 1'b0, 1'b0, 16'h0000);
        do_op(8'h7F, 8'd1, 2, 1'b0, 1'b1, 16'h007F);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            if (ra == 8'h80) ra = 8'h81;
            rb = 8'($urandom);
            do_op(ra, rb, $urandom_range(0, 3), bit'($urandom_range(0, 1)), 1'b0, 16'h0000);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
